exu_ctrl: RTL and testbench

//   Handshake/sequencing controller for the EXU data-package register. Sits between IDU (pre) and LSU (post).

---
 rtl/exu_ctrl.sv | 128 ++++++++++++
 tb/tb_exu_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exu_ctrl
// Brief    : Handshake and sequencing controller for the EXU package register,
//            with multi-cycle ALU start/capture strobes, flush and perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module exu_ctrl #(
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 3,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pre_valid,
    output logic              o_pre_ready,
    output logic              o_post_valid,
    input  logic              i_post_ready,
    input  logic              i_multi_cycle,
    input  logic              i_flush,
    output logic              o_pkg_wen,
    output logic              o_alu_start,
    output logic              o_res_wen,
    output logic              o_busy,
    output logic [PERF_W-1:0] o_busy_cycles,
    output logic [PERF_W-1:0] o_stall_cycles
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXEC    = 2'd1,
        S_DONE    = 2'd2,
        S_ILLEGAL = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(MC_LAT - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_zero = '0;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [PERF_W-1:0]   r_busy_cycles;
    logic [PERF_W-1:0]   r_stall_cycles;

    logic                w_pre_ready;
    logic                w_accept;
    logic                w_exec_last;
    state_t              w_issue_state;

    // Every handshake output is held low while reset is asserted.
    always_comb begin
        w_pre_ready = 1'b0;
        case (r_state)
            S_IDLE:  w_pre_ready = 1'b1;
            S_DONE:  w_pre_ready = i_post_ready;
            default: w_pre_ready = 1'b0;
        endcase
        if (!rst) begin
            w_pre_ready = 1'b0;
        end
    end

    assign w_accept      = i_pre_valid & w_pre_ready & ~i_flush;
    assign w_exec_last   = rst & (r_state == S_EXEC) & (r_cnt == c_cnt_one) & ~i_flush;
    assign w_issue_state = i_multi_cycle ? S_EXEC : S_DONE;

    assign o_pre_ready    = w_pre_ready;
    assign o_pkg_wen      = w_accept;
    assign o_alu_start    = w_accept & i_multi_cycle;
    assign o_res_wen      = w_exec_last;
    assign o_post_valid   = rst & (r_state == S_DONE) & ~i_flush;
    assign o_busy         = rst & (r_state == S_EXEC);
    assign o_busy_cycles  = r_busy_cycles;
    assign o_stall_cycles = r_stall_cycles;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= c_cnt_zero;
            r_busy_cycles  <= '0;
            r_stall_cycles <= '0;
        end else begin
            if ((r_state == S_EXEC) && !i_flush) begin
                r_busy_cycles <= r_busy_cycles + 1'b1;
            end
            if ((r_state == S_DONE) && !i_post_ready && !i_flush) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end

            if (i_flush) begin
                r_state <= S_IDLE;
                r_cnt   <= c_cnt_zero;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_state <= w_issue_state;
                            r_cnt   <= i_multi_cycle ? c_cnt_load : c_cnt_zero;
                        end
                    end
                    S_EXEC: begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == c_cnt_one) begin
                            r_state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        // A handoff may coincide with the next accept.
                        if (i_post_ready) begin
                            if (w_accept) begin
                                r_state <= w_issue_state;
                                r_cnt   <= i_multi_cycle ? c_cnt_load : c_cnt_zero;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= c_cnt_zero;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_exu_ctrl
// Brief    : Self-checking bench for exu_ctrl: vector table, corner sequences
//            and randomized traffic against a latency-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exu_ctrl;

    localparam int MC_LAT = 4;
    localparam int CNT_W  = 3;
    localparam int PERF_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              pre_valid, post_ready, multi_cycle, flush;
    logic              pre_ready, post_valid, pkg_wen, alu_start, res_wen, busy;
    logic [PERF_W-1:0] busy_cycles, stall_cycles;

    int total = 0;
    int bad   = 0;

    exu_ctrl #(.MC_LAT(MC_LAT), .CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pre_valid    (pre_valid),
        .o_pre_ready    (pre_ready),
        .o_post_valid   (post_valid),
        .i_post_ready   (post_ready),
        .i_multi_cycle  (multi_cycle),
        .i_flush        (flush),
        .o_pkg_wen      (pkg_wen),
        .o_alu_start    (alu_start),
        .o_res_wen      (res_wen),
        .o_busy         (busy),
        .o_busy_cycles  (busy_cycles),
        .o_stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pv, pr, mc, fl;
        logic [5:0] exp;   // {pre_ready, post_valid, pkg_wen, alu_start, res_wen, busy}
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic pr, input logic mc, input logic fl);
        pre_valid   = pv;
        post_ready  = pr;
        multi_cycle = mc;
        flush       = fl;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: an in-flight op plus the number of cycles left before its result is visible.
    bit          m_op;
    int          m_left;
    int unsigned m_busy, m_stall;

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b100000};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b101000};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b110000};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b100000};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 6'b101100};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000001};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000001};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000011};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b010000};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b010000};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b111000};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'b111100};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'b000001};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 6'b100000};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b101000};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 6'b100000};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b100000};

        // Reset held with a pending request: everything quiet.
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {pre_ready, post_valid, pkg_wen, alu_start, res_wen, busy}, 6'b0);
        chk("rst_busy_cnt", busy_cycles, 0);
        chk("rst_stall_cnt", stall_cycles, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        chk("rel_pre_ready", pre_ready, 1'b1);
        chk("rel_counters", {busy_cycles, stall_cycles}, 64'd0);
        next_cycle();

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].pv, vecs[i].pr, vecs[i].mc, vecs[i].fl);
            #4;
            chk($sformatf("vec%0d", i), {pre_ready, post_valid, pkg_wen, alu_start, res_wen, busy},
                vecs[i].exp);
            next_cycle();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("vec_busy_cnt", busy_cycles, 3);
        chk("vec_stall_cnt", stall_cycles, 2);
        next_cycle();

        // Backpressure: five stalled DONE cycles then exactly one handoff.
        begin
            logic [PERF_W-1:0] base;
            base = stall_cycles;
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            next_cycle();
            for (int i = 0; i < 5; i++) begin
                drive(1'b1, 1'b0, 1'b0, 1'b0);
                #4;
                chk($sformatf("bp_hold%0d", i), {pre_ready, post_valid, pkg_wen}, 3'b010);
                next_cycle();
            end
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            #4;
            chk("bp_handoff", {pre_ready, post_valid}, 2'b11);
            chk("bp_stall_delta", stall_cycles - base, 5);
            next_cycle();
            #4;
            chk("bp_single", post_valid, 1'b0);
            next_cycle();
        end

        // Flush in EXEC two cycles after accept.
        begin
            logic [PERF_W-1:0] base;
            base = busy_cycles;
            drive(1'b1, 1'b1, 1'b1, 1'b0);
            #4;
            chk("fl_start", alu_start, 1'b1);
            next_cycle();
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            #4;
            chk("fl_t1", {busy, res_wen}, 2'b10);
            next_cycle();
            drive(1'b0, 1'b1, 1'b0, 1'b1);
            #4;
            chk("fl_t2", {res_wen, post_valid}, 2'b00);
            next_cycle();
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 5; i++) begin
                #4;
                chk($sformatf("fl_after%0d", i), {pre_ready, post_valid, res_wen, busy}, 4'b1000);
                next_cycle();
            end
            chk("fl_busy_delta", busy_cycles - base, 1);
        end

        // Asynchronous reset in the middle of a multi-cycle op.
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        next_cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #2;
        chk("mr_during", {pre_ready, busy, busy_cycles}, 34'd0);
        next_cycle();
        rst = 1'b1;
        #3;
        chk("mr_release", {pre_ready, post_valid, res_wen}, 3'b100);
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            #4;
            chk($sformatf("mr_quiet%0d", i), {post_valid, res_wen, busy}, 3'b000);
            next_cycle();
        end

        // Randomized traffic against the reference model; model restarts from reset.
        rst = 1'b0;
        #2;
        rst = 1'b1;
        m_op = 0; m_left = 0; m_busy = 0; m_stall = 0;
        next_cycle();
        for (int n = 0; n < 3000; n++) begin
            bit pv, pr, mc, fl, e_ready, e_valid, e_acc, e_busy, e_res;
            pv = ($urandom_range(0, 3) != 0);
            pr = ($urandom_range(0, 3) != 0);
            mc = $urandom_range(0, 1);
            fl = ($urandom_range(0, 15) == 0);
            drive(pv, pr, mc, fl);
            e_ready = !m_op || (m_left == 0 && pr);
            e_valid = m_op && m_left == 0 && !fl;
            e_acc   = pv && e_ready && !fl;
            e_busy  = m_op && m_left > 0;
            e_res   = m_op && m_left == 1 && !fl;
            #4;
            chk("rnd_pre_ready", pre_ready, e_ready);
            chk("rnd_post_valid", post_valid, e_valid);
            chk("rnd_pkg_wen", pkg_wen, e_acc);
            chk("rnd_alu_start", alu_start, e_acc && mc);
            chk("rnd_res_wen", res_wen, e_res);
            chk("rnd_busy", busy, e_busy);
            chk("rnd_busy_cnt", busy_cycles, m_busy);
            chk("rnd_stall_cnt", stall_cycles, m_stall);
            if (e_busy && !fl) m_busy++;
            if (m_op && m_left == 0 && !pr && !fl) m_stall++;
            if (fl) begin
                m_op = 0;
            end else begin
                if (m_op && m_left > 0) m_left--;
                else if (m_op && pr) m_op = 0;
                if (e_acc) begin
                    m_op   = 1;
                    m_left = mc ? MC_LAT - 1 : 0;
                end
            end
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
        $fatal(1);
    end

endmodule
`default_nettype wire
